// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit for the EX stage.
// Executes MULT (00), MULTU (01), DIV (10) and DIVU (11) on WIDTH-bit operands.
// Multiply is iterative shift-add (WIDTH cycles), or a single cycle when MUL_FAST=1.
// Divide is restoring radix-2 (WIDTH cycles).
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   start, op, a, b  request and operands; captured when the unit is not in CALC
//   cancel           flush; aborts an operation in CALC
//   busy             high while the unit is in CALC
//   done             one-cycle pulse; hi/lo hold the new result
//   hi, lo           product high/low, or remainder/quotient
module mul_div_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_FAST = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              w_accept, w_last;
  logic [CW-1:0]     r_cnt;
  logic              r_is_div, r_neg_res, r_neg_rem, r_div0;
  logic [WIDTH-1:0]  r_mcand;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  r_acc_hi, r_acc_lo;
  logic [WIDTH-1:0]  r_res_hi, r_res_lo;

  logic              w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]  w_a_mag, w_b_mag;
  logic [WIDTH:0]    w_msum, w_dshift;
  logic [WIDTH-1:0]  w_ddiff;
  logic              w_dge;
  logic [2*WIDTH-1:0] w_fprod, w_prod_fix;
  logic [WIDTH-1:0]  w_step_hi, w_step_lo, w_fix_hi, w_fix_lo;

  function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_cneg2(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_DONE);
  assign hi   = r_res_hi;
  assign lo   = r_res_lo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // cancel outranks start; start is only considered outside CALC
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_CALC: begin
        if (cancel) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        if (start && !cancel) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Signed ops (op[0]=0) work on magnitudes; signs are re-applied at the end
  always_comb begin
    w_signed = ~op[0];
    w_a_neg  = w_signed & a[WIDTH-1];
    w_b_neg  = w_signed & b[WIDTH-1];
    w_a_mag  = f_cneg(a, w_a_neg);
    w_b_mag  = f_cneg(b, w_b_neg);
  end

  // One iteration of the selected algorithm
  always_comb begin
    w_msum   = {1'b0, r_acc_hi} + {1'b0, r_mcand & {WIDTH{r_acc_lo[0]}}};
    w_fprod  = {{WIDTH{1'b0}}, r_mcand} * {{WIDTH{1'b0}}, r_acc_lo};
    // partial remainder shifted left with the next dividend bit
    w_dshift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_dge    = (w_dshift >= {1'b0, r_mcand});
    w_ddiff  = w_dshift[WIDTH-1:0] - r_mcand;
    if (r_is_div) begin
      w_step_hi = w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
      w_step_lo = {r_acc_lo[WIDTH-2:0], w_dge};
    end else if (MUL_FAST != 0) begin
      {w_step_hi, w_step_lo} = w_fprod;
    end else begin
      w_step_hi = w_msum[WIDTH:1];
      w_step_lo = {w_msum[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up on the final iteration's result. A zero divisor keeps the
  // all-ones quotient; the remainder then equals the original dividend.
  always_comb begin
    w_prod_fix = f_cneg2({w_step_hi, w_step_lo}, r_neg_res);
    if (r_is_div) begin
      w_fix_lo = f_cneg(w_step_lo, r_neg_res & ~r_div0);
      w_fix_hi = f_cneg(w_step_hi, r_neg_rem);
    end else begin
      w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_res_hi  <= '0;
      r_res_lo  <= '0;
    end else if (w_accept) begin
      r_is_div  <= op[1];
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_div0    <= (b == '0);
      r_acc_hi  <= '0;
      if (op[1]) begin
        r_mcand  <= w_b_mag;
        r_acc_lo <= w_a_mag;
      end else begin
        r_mcand  <= w_a_mag;
        r_acc_lo <= w_b_mag;
      end
      r_cnt <= (MUL_FAST != 0 && !op[1]) ? CW'(1) : CW'(WIDTH);
    end else if (r_state == S_CALC && !cancel) begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      r_cnt    <= r_cnt - CW'(1);
      if (w_last) begin
        r_res_hi <= w_fix_hi;
        r_res_lo <= w_fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: one iterative instance (MUL_FAST=0)
// and one single-cycle-multiply instance (MUL_FAST=1) sharing the same inputs.
module tb_mul_div_unit;

  logic        clk, resetn, start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy_s, done_s, busy_f, done_f;
  logic [31:0] hi_s, lo_s, hi_f, lo_f;
  logic        sel;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32), .MUL_FAST(0)) dut_s (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s)
  );

  mul_div_unit #(.WIDTH(32), .MUL_FAST(1)) dut_f (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy_f), .done(done_f), .hi(hi_f), .lo(lo_f)
  );

  assign o_busy = sel ? busy_f : busy_s;
  assign o_done = sel ? done_f : done_s;
  assign o_hi   = sel ? hi_f   : hi_s;
  assign o_lo   = sel ? lo_f   : lo_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a request in the current cycle, then checks latency and result in the done cycle
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int lat,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; op = 2'b01;
    n = 0;
    while (o_busy && n < lat + 8) begin
      n++;
      step();
    end
    chk({tag, "_lat"},  64'(n),      64'(lat));
    chk({tag, "_done"}, 64'(o_done), 64'd1);
    chk({tag, "_hi"},   64'(o_hi),   64'(eh));
    chk({tag, "_lo"},   64'(o_lo),   64'(el));
  endtask

  initial begin
    int  n;
    logic seen_busy, seen_done;
    sel = 1'b0; resetn = 1'b1; start = 1'b0; cancel = 1'b0;
    op = 2'b00; a = '0; b = '0;
    #3 resetn = 1'b0;
    step(); step();
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_done", 64'(done_s), 64'd0);
    chk("rst_hi",   64'(hi_s),   64'd0);
    chk("rst_lo",   64'(lo_s),   64'd0);
    resetn = 1'b1;
    step();

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001);
    step();
    chk("idle_after_done", 64'(done_s), 64'd0);

    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("b2b_multu", 2'b01, 32'd2, 32'd3, 32, 32'h0, 32'd6);
    step();

    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    step();
    run_op("divu", 2'b11, 32'd7, 32'd2, 32, 32'd1, 32'd3);
    step();
    run_op("divu_by0", 2'b11, 32'h1234, 32'd0, 32, 32'h1234, 32'hFFFFFFFF);
    step();
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32, 32'h0, 32'h80000000);
    step();
    run_op("div_neg_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 32, 32'hFFFFFFF9, 32'hFFFFFFFF);
    step();

    // cancel in the 10th CALC cycle together with a start pulse
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    chk("cancel_pre_busy", 64'(busy_s), 64'd1);
    step();
    cancel = 1'b1; start = 1'b1; op = 2'b11; a = 32'd7; b = 32'd2;
    step();
    cancel = 1'b0; start = 1'b0;
    chk("cancel_busy", 64'(busy_s), 64'd0);
    chk("cancel_done", 64'(done_s), 64'd0);
    chk("cancel_hi",   64'(hi_s),   64'hFFFFFFF9);
    chk("cancel_lo",   64'(lo_s),   64'hFFFFFFFF);
    seen_busy = 1'b0; seen_done = 1'b0;
    repeat (40) begin
      step();
      seen_busy |= busy_s;
      seen_done |= done_s;
    end
    chk("cancel_no_busy", 64'(seen_busy), 64'd0);
    chk("cancel_no_done", 64'(seen_done), 64'd0);

    // start during CALC is ignored and not queued
    op = 2'b11; a = 32'd7; b = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    n = 5;
    while (busy_s && n < 40) begin
      n++;
      step();
    end
    chk("calc_start_lat",  64'(n),      64'd32);
    chk("calc_start_done", 64'(done_s), 64'd1);
    chk("calc_start_hi",   64'(hi_s),   64'd1);
    chk("calc_start_lo",   64'(lo_s),   64'd3);
    step();
    chk("calc_start_not_queued", 64'(busy_s), 64'd0);

    // start together with cancel outside CALC stays idle
    start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("idle_start_cancel_busy", 64'(busy_s), 64'd0);
    step();
    chk("idle_start_cancel_done", 64'(done_s), 64'd0);

    // single-cycle multiply instance
    sel = 1'b1;
    run_op("fast_mult", 2'b00, 32'd5, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFB);
    step();
    run_op("fast_divu", 2'b11, 32'd7, 32'd2, 32, 32'd1, 32'd3);
    sel = 1'b0;
    repeat (40) step();
    chk("pre_reset_hi", 64'(hi_s), 64'hFFFFFFFF);

    // asynchronous reset in the middle of a divide
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("midrst_pre_busy", 64'(busy_s), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_s), 64'd0);
    chk("midrst_done", 64'(done_s), 64'd0);
    chk("midrst_hi",   64'(hi_s),   64'd0);
    chk("midrst_lo",   64'(lo_s),   64'd0);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_busy", 64'(busy_s), 64'd0);
    chk("post_rst_done", 64'(done_s), 64'd0);
    run_op("post_rst_divu", 2'b11, 32'd100, 32'd7, 32, 32'd2, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit for the EX stage. Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands and produces a HI/LO result pair. It replaces the single-cycle behaviour implied by the MULT/DIV ALU control codes. The stage controller uses `busy` to stall the pipeline and `cancel` to flush the unit on an exception.

## Interface
- `WIDTH`, 32: operand width; even, ≥ 4.
- `MUL_FAST`, 0: 1 = multiply completes in one CALC cycle (native `*`); 0 = iterative shift-add.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when state ≠ CALC.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with `start`.
- `a`  in  WIDTH  multiplicand/dividend; captured with `start`.
- `b`  in  WIDTH  multiplier/divisor; captured with `start`.
- `cancel`  in  1  flush; aborts an operation in CALC.
- `busy`  out  1  high while state = CALC.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid.
- `hi`  out  WIDTH  product upper half, or remainder.
- `lo`  out  WIDTH  product lower half, or quotient.

## Operation
- One clock domain, `clk`. Reset is asynchronous and active-low on `resetn`.
- Reset state: IDLE. Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0; counter and work registers 0.
- States: IDLE, CALC, DONE.
  - IDLE or DONE with `start`=1 and `cancel`=0: capture `op`, `a`, `b` → CALC. Load the counter with WIDTH, or 1 for a multiply when `MUL_FAST`=1.
  - IDLE or DONE with no accepted start: → IDLE.
  - CALC: perform one iteration per cycle and decrement the counter.
    - `cancel`=1 → IDLE. `hi`/`lo` are unchanged and no `done` is produced.
    - Last iteration (counter = 1): apply sign fix-up, load `hi`/`lo` → DONE.
- `start` with `cancel` in the same cycle: `cancel` wins and `start` is ignored.
- `start` while in CALC is ignored and is not queued.
- `cancel` in IDLE or DONE has no effect. A result already in DONE stays committed.
- Signed ops (MULT, DIV) run on operand magnitudes (two's-complement negate if MSB=1). Unsigned ops use the operands as-is.
- Multiply:
  - 2·WIDTH-bit product from WIDTH shift-add steps.
  - Negate the product if the operand signs differ (signed only).
  - `hi` = product[2W-1:W], `lo` = product[W-1:0].
- Divide:
  - Restoring radix-2, one quotient bit per cycle, MSB first.
  - Signed: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - `lo` = quotient, `hi` = remainder.
  - Divisor = 0: `lo` = all ones, `hi` = dividend (unmodified). Still takes the full latency.
  - Signed overflow (min_int / −1): `lo` = min_int, `hi` = 0. This falls out of the magnitude algorithm; no special case.
- `hi`/`lo` hold their value until the next DONE entry or reset.

## Timing
- Accept edge T: `start` is sampled high with state ≠ CALC. Operands need not be held after T.
- `busy` is high in cycles T+1 … T+L, where L = WIDTH, or 1 for a multiply with `MUL_FAST`=1.
- `done` is high in cycle T+L+1 only; `hi`/`lo` are valid from that cycle.
- Back-to-back: a `start` sampled in the DONE cycle is accepted. That gives one result every L+1 cycles.
- Cancel sampled at edge C during CALC: `busy` is low from cycle C+1.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). Release is synchronous to `clk`.
- No combinational path from any input to any output.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, `MUL_FAST`=0 → `busy` high for 32 cycles; `done` at T+33 with `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then back-to-back start in the DONE cycle with MULTU 2×3 → `lo`=6 at T+33+33.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=2 → `lo`=3, `hi`=1.
- DIVU a=0x1234, b=0 → `lo`=0xFFFFFFFF, `hi`=0x1234. DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Start a DIV, assert `cancel` in the 10th CALC cycle while also pulsing `start` → `busy` low next cycle, no `done`, `hi`/`lo` hold the prior result. Also: `start` during CALC is ignored, and `start`+`cancel` in IDLE stays IDLE.
- `MUL_FAST`=1 MULT 5×(−1) → `done` at T+2 with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFB. Drop `resetn` mid-DIV → `busy`/`done`/`hi`/`lo`=0 asynchronously; after release, state is IDLE.
